// File: rtl/imm_gen_arbiter.sv
// imm_gen_arbiter
// Shares one combinational immediate generator between the decode stage
// (req0) and the fetch-stage branch-target predictor (req1). At most one
// request is granted per cycle. The opcode of the granted instruction is
// decoded into the generator's format select. The generator's immediate is
// captured into a one-entry valid/ready output register.
module imm_gen_arbiter #(
  parameter int TAG_W      = 4,
  parameter int PRIO_FIXED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_instr,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_instr,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic [2:0]       imm_sel,
  output logic [31:0]      imm_instr,
  input  logic [31:0]      imm_in,
  output logic             out_valid,
  output logic [31:0]      out_imm,
  output logic             out_src,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  input  logic             out_ready
);

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b100;

  // Returns {illegal, select} for a 7-bit opcode. JALR deliberately maps to
  // the I format; the J path of the generator is reserved for JAL.
  function automatic logic [3:0] decode_opcode(input logic [6:0] opcode);
    logic [3:0] res;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: res = {1'b0, SEL_I};
      7'b0100011:                         res = {1'b0, SEL_S};
      7'b1100011:                         res = {1'b0, SEL_B};
      7'b0110111, 7'b0010111:             res = {1'b0, SEL_U};
      7'b1101111:                         res = {1'b0, SEL_J};
      default:                            res = {1'b1, SEL_I};
    endcase
    return res;
  endfunction

  logic             accept_s;
  logic             grant_any_s;
  logic             grant_idx_s;
  logic             rr_last_r;
  logic [31:0]      granted_instr_s;
  logic [TAG_W-1:0] granted_tag_s;
  logic [3:0]       decode_s;
  logic             illegal_s;

  // Arbitration: pick at most one requester when the output slot can take a result.
  always_comb begin
    accept_s    = ~out_valid | out_ready;
    grant_any_s = 1'b0;
    grant_idx_s = 1'b0;
    if (!rst && accept_s) begin
      if (req0_valid && req1_valid) begin
        grant_any_s = 1'b1;
        if (PRIO_FIXED != 0) begin
          grant_idx_s = 1'b0;
        end else begin
          // Round-robin: serve whichever requester was not served last.
          grant_idx_s = (rr_last_r == 1'b0) ? 1'b1 : 1'b0;
        end
      end else if (req0_valid) begin
        grant_any_s = 1'b1;
        grant_idx_s = 1'b0;
      end else if (req1_valid) begin
        grant_any_s = 1'b1;
        grant_idx_s = 1'b1;
      end else begin
        grant_any_s = 1'b0;
        grant_idx_s = 1'b0;
      end
    end else begin
      grant_any_s = 1'b0;
      grant_idx_s = 1'b0;
    end
  end

  // Route the granted request to the generator and decode its opcode.
  always_comb begin
    granted_instr_s = 32'h0000_0000;
    granted_tag_s   = {TAG_W{1'b0}};
    decode_s        = {1'b0, SEL_I};
    if (grant_any_s) begin
      if (grant_idx_s) begin
        granted_instr_s = req1_instr;
        granted_tag_s   = req1_tag;
      end else begin
        granted_instr_s = req0_instr;
        granted_tag_s   = req0_tag;
      end
      decode_s = decode_opcode(granted_instr_s[6:0]);
    end else begin
      granted_instr_s = 32'h0000_0000;
      granted_tag_s   = {TAG_W{1'b0}};
      decode_s        = {1'b0, SEL_I};
    end
    illegal_s  = decode_s[3];
    imm_sel    = decode_s[2:0];
    imm_instr  = granted_instr_s;
    req0_ready = grant_any_s & ~grant_idx_s;
    req1_ready = grant_any_s & grant_idx_s;
  end

  // Remember the last served requester; untouched on cycles with no grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= 1'b1;
    end else if (grant_any_s) begin
      rr_last_r <= grant_idx_s;
    end else begin
      rr_last_r <= rr_last_r;
    end
  end

  // One-entry result register: load on grant, drain on out_ready, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_imm     <= 32'h0000_0000;
      out_src     <= 1'b0;
      out_tag     <= {TAG_W{1'b0}};
      out_illegal <= 1'b0;
    end else if (grant_any_s) begin
      out_valid   <= 1'b1;
      out_imm     <= illegal_s ? 32'h0000_0000 : imm_in;
      out_src     <= grant_idx_s;
      out_tag     <= granted_tag_s;
      out_illegal <= illegal_s;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end else begin
      out_valid   <= out_valid;
    end
  end

endmodule
